ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle RV32M divider in the execute stage.
- Consumes the decoded operands and destination register registered by the ID/EX pipeline register.
- Iterates a 32-step restoring division and returns quotient or remainder with a one-cycle ready pulse.
- While busy, EX raises the pipeline hold so ID/EX and upstream stages freeze; a jump/flush from EX aborts the operation.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset; all state is reset on the rising clk edge while rst==0.
- start_i  input  1  request a division; held high by EX until ready_o.
- op_i  input  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
- dividend_i  input  XLEN  rs1 value.
- divisor_i  input  XLEN  rs2 value.
- reg_waddr_i  input  5  destination register of the request.
- flush_i  input  1  abort the current operation (jump/mispredict taken in EX).
- result_o  output  XLEN  quotient or remainder, valid when ready_o==1, else 0.
- ready_o  output  1  one-cycle completion pulse.
- busy_o  output  1  operation in flight; EX converts it to a hold request.
- reg_waddr_o  output  5  destination latched at accept; valid with ready_o.

Behaviour:
- States: IDLE, START, CALC, END.
- Reset: state=IDLE, counter=0; result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0.
- IDLE:
  - start_i==1 and flush_i==0 -> latch op, operands and reg_waddr_i; go to START.
  - Otherwise stay in IDLE; busy_o=0.
- START (1 cycle, busy_o=1):
  - Divisor==0 -> load the forced result and go to END.
  - Otherwise, for DIV/REM, take magnitudes (two's-complement negate negative operands) and record both signs; DIVU/REMU use the raw operands.
  - Clear the partial remainder, counter=0; go to CALC.
- CALC (busy_o=1), one iteration per cycle, MSB first:
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor: rem -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - When counter reaches XLEN-1, go to END.
- END (busy_o=0, ready_o=1 for exactly one cycle):
  - result_o = quotient for DIV/DIVU, remainder for REM/REMU.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Next state is IDLE.
- Latency: accept at cycle N -> ready_o at N+34 in the normal path, N+2 for divide-by-zero.
- Divide by zero: quotient = 32'hFFFF_FFFF for both signed and unsigned; remainder = dividend unchanged.
- Overflow, DIV/REM of 32'h8000_0000 by 32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0. This falls out of the magnitude datapath and needs no special case.
- start_i is sampled only in IDLE. A start_i level in END is ignored; EX must deassert start_i in the cycle after ready_o or a new operation is accepted.
- flush_i in any state -> IDLE on the next edge; ready_o is not asserted for the aborted operation; busy_o=0 from the next cycle.
- flush_i and ready_o in the same cycle: the result is discarded by EX; the block still returns to IDLE.
- Reset mid-operation: returns to IDLE on the next edge and drives all outputs to their reset values, with no ready_o.
- Arithmetic: the partial remainder is XLEN+1 bits wide for the subtract/compare; all negations are modulo 2^XLEN.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in START, an unsigned dividend magnitude less than the divisor magnitude skips CALC. Quotient=0 and remainder=dividend, with the normal sign fix-up; latency N+2.
- Undefined: these cases run the full 32 iterations; results are identical, only latency differs.

Decomposition:
- Shared defines: funct3 codes (INST_DIV, INST_DIVU, INST_REM, INST_REMU), state encodings, ZeroWord, ZeroReg.
- State is encoded one-hot, 4 bits.
- No sub-module is needed. The single-step compare/subtract may be a function inside ex_div; a separate module is not justified.

Test Plan:
- DIVU 100/7, start at cycle 0 -> ready_o pulse at cycle 34 with result_o=14, reg_waddr_o=latched value; busy_o high for cycles 1-33.
- REM -7/2 -> result_o=32'hFFFF_FFFF (-1); DIV -7/2 -> 32'hFFFF_FFFD (-3).
- DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000; REM of the same operands -> 0.
- DIVU 5/0 -> 32'hFFFF_FFFF at cycle 2; REMU 5/0 -> 5.
- DIV 5/0 -> 32'hFFFF_FFFF.
- Start DIV 1000/3, assert flush_i at cycle 10 -> IDLE at cycle 11, no ready_o.
- Then a new DIVU 9/3 -> result_o=3 at 34 cycles after accept.
- Drive rst=0 at cycle 15 of an operation -> all outputs 0 next cycle, no ready_o.
- Also hold start_i high through END -> second operation accepted only in the cycle after the ready_o pulse.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ----------------------------------------------------------------------------
// ex_div_pkg
// Shared definitions for the RV32M execute-stage divider:
//   - funct3 codes for DIV / DIVU / REM / REMU
//   - one-hot FSM state encoding (4 bits)
//   - zero constants for the result word and register address
// ----------------------------------------------------------------------------
package ex_div_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [4:0]  ZeroReg  = 5'h00;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_CALC  = 4'b0100,
        ST_END   = 4'b1000
    } div_state_t;

endpackage

// File: rtl/ex_div.sv
// ----------------------------------------------------------------------------
// ex_div
// Multi-cycle RV32M divider living in the execute stage. A request is latched
// in IDLE, operands are converted to magnitudes in START, 32 restoring
// division steps run in CALC (one per cycle, MSB first), and END presents the
// sign-corrected quotient or remainder with a one-cycle ready pulse.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   start_i      division request, held by EX until ready_o
//   op_i         funct3 (DIV/DIVU/REM/REMU)
//   dividend_i   rs1 value
//   divisor_i    rs2 value
//   reg_waddr_i  destination register of the request
//   flush_i      abort the operation in flight
//   result_o     quotient or remainder, valid with ready_o, else 0
//   ready_o      one-cycle completion pulse
//   busy_o       operation in flight (START/CALC); EX turns it into a hold
//   reg_waddr_o  destination latched at accept, valid with ready_o
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, a dividend magnitude smaller than the
//                     divisor magnitude skips CALC (quotient 0, remainder =
//                     dividend). Results are identical either way; only the
//                     latency changes.
// ----------------------------------------------------------------------------
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o
);

    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } step_t;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // from the (XLEN+1)-bit partial remainder and shift the quotient bit in.
    function automatic step_t div_step(input logic [XLEN-1:0] rem,
                                       input logic [XLEN-1:0] quo,
                                       input logic [XLEN-1:0] dvs);
        logic [XLEN:0] shifted;
        step_t         s;
        shifted = {rem, quo[XLEN-1]};
        if (shifted >= {1'b0, dvs}) begin
            // The true difference is below dvs, so XLEN bits hold it exactly.
            s.rem = shifted[XLEN-1:0] - dvs;
            s.quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            s.rem = shifted[XLEN-1:0];
            s.quo = {quo[XLEN-2:0], 1'b0};
        end
        return s;
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return {XLEN{1'b0}} - v;
    endfunction

    div_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic            is_signed_r;
    logic            is_rem_r;
    logic            neg_q_r;
    logic            neg_r_r;
    // dividend_r holds the raw dividend in START and the quotient
    // being shifted in during CALC.
    logic [XLEN-1:0] dividend_r;
    logic [XLEN-1:0] divisor_r;
    logic [XLEN-1:0] rem_r;

    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    step_t           step;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign dvd_neg = is_signed_r & dividend_r[XLEN-1];
    assign dvs_neg = is_signed_r & divisor_r[XLEN-1];
    assign mag_a   = dvd_neg ? negate(dividend_r) : dividend_r;
    assign mag_b   = dvs_neg ? negate(divisor_r)  : divisor_r;

    assign step    = div_step(rem_r, dividend_r, divisor_r);
    assign q_fix   = neg_q_r ? negate(step.quo) : step.quo;
    assign r_fix   = neg_r_r ? negate(step.rem) : step.rem;

    // NOTE: all state here is sequential, so every assignment in this block
    // is non-blocking; mixing in blocking writes would make the order of
    // reads inside the block change the hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the datapath registers are reset along with the FSM so a
            // reset mid-operation leaves no stale operands or sign flags.
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            is_signed_r <= 1'b0;
            is_rem_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dividend_r  <= ZeroWord;
            divisor_r   <= ZeroWord;
            rem_r       <= ZeroWord;
            result_o    <= ZeroWord;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= ZeroReg;
        end else begin
            // The result is only presented alongside the ready pulse.
            ready_o  <= 1'b0;
            result_o <= ZeroWord;

            if (flush_i) begin
                state_r <= ST_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_i) begin
                            is_signed_r <= (op_i == INST_DIV) || (op_i == INST_REM);
                            is_rem_r    <= (op_i == INST_REM) || (op_i == INST_REMU);
                            dividend_r  <= dividend_i;
                            divisor_r   <= divisor_i;
                            reg_waddr_o <= reg_waddr_i;
                            busy_o      <= 1'b1;
                            state_r     <= ST_START;
                        end
                    end

                    ST_START: begin
                        if (divisor_r == ZeroWord) begin
                            // Divide by zero: all-ones quotient, remainder is
                            // the dividend exactly as supplied.
                            result_o <= is_rem_r ? dividend_r : {XLEN{1'b1}};
                            ready_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state_r  <= ST_END;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (mag_a < mag_b) begin
                            // |a| < |b|: quotient 0; the sign-fixed remainder
                            // is the original dividend.
                            result_o <= is_rem_r ? dividend_r : ZeroWord;
                            ready_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state_r  <= ST_END;
                        end
`endif
                        else begin
                            dividend_r <= mag_a;
                            divisor_r  <= mag_b;
                            neg_q_r    <= dvd_neg ^ dvs_neg;
                            neg_r_r    <= dvd_neg;
                            rem_r      <= ZeroWord;
                            cnt_r      <= '0;
                            state_r    <= ST_CALC;
                        end
                    end

                    ST_CALC: begin
                        rem_r      <= step.rem;
                        dividend_r <= step.quo;
                        cnt_r      <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(XLEN - 1)) begin
                            result_o <= is_rem_r ? r_fix : q_fix;
                            ready_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state_r  <= ST_END;
                        end
                    end

                    ST_END: begin
                        // start_i is deliberately ignored here.
                        state_r <= ST_IDLE;
                    end

                    default: begin
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// ----------------------------------------------------------------------------
// tb_ex_div
// Self-checking bench for ex_div. Each request pushes its expected result,
// destination and completion cycle onto a scoreboard; a monitor pops and
// compares on every ready_o pulse. Aborted operations push nothing, so any
// ready_o with an empty scoreboard is counted as spurious.
// Honours DIV_EARLY_OUT_EN for the expected latency.
// ----------------------------------------------------------------------------
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    ex_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .reg_waddr_o(reg_waddr_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  wa;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   spurious  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference result using the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] model_res(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            INST_REMU: return (b == 0) ? a : a % b;
            INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF :
                              ovf      ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            default:   return (b == 0) ? a :
                              ovf      ? 32'h0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
        begin
            logic        sgn;
            logic [31:0] ma;
            logic [31:0] mb;
            sgn = (op == INST_DIV) || (op == INST_REM);
            ma  = (sgn && a[31]) ? 32'(-a) : a;
            mb  = (sgn && b[31]) ? 32'(-b) : b;
            if (ma < mb) return 2;
        end
`else
        if (op == 3'b000) return 34;
`endif
        return 34;
    endfunction

    // Monitor: every ready pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (ready_o) begin
            if (sb.size() == 0) begin
                spurious++;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_res"}, result_o, e.res);
                check({e.tag, "_waddr"}, 32'(reg_waddr_o), 32'(e.wa));
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one request (DUT idle), hold start until ready, count busy cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input string tag);
        int lat;
        int busy_n;
        bit seen;
        @(negedge clk);
        lat = model_lat(op, a, b);
        sb.push_back('{tag, model_res(op, a, b), wa, cyc + lat});
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        busy_n = 0;
        seen   = 1'b0;
        for (int w = 0; w < 60 && !seen; w++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
            else if (busy_o) busy_n++;
        end
        start_i = 1'b0;
        check({tag, "_done"}, 32'(seen), 32'd1);
        if (!seen) sb.delete();
        check({tag, "_busy"}, 32'(busy_n), 32'(lat - 1));
    endtask

    // Start an operation that will be aborted; nothing is pushed.
    task automatic start_abort(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wa);
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        start_i     = 1'b0;
        op_i        = INST_DIVU;
        dividend_i  = 32'h0;
        divisor_i   = 32'h0;
        reg_waddr_i = 5'h0;
        flush_i     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", result_o, 32'h0);
        check("rst_ready", 32'(ready_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_waddr", 32'(reg_waddr_o), 32'h0);
        rst = 1'b1;

        // Directed cases
        run_op(INST_DIVU, 32'd100, 32'd7, 5'd11, "divu_100_7");
        run_op(INST_REM,  32'hFFFF_FFF9, 32'd2, 5'd3, "rem_m7_2");
        run_op(INST_DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, "div_m7_2");
        run_op(INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, "div_ovf");
        run_op(INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, "rem_ovf");
        run_op(INST_DIVU, 32'd5, 32'd0, 5'd7, "divu_5_0");
        run_op(INST_REMU, 32'd5, 32'd0, 5'd8, "remu_5_0");
        run_op(INST_DIV,  32'd5, 32'd0, 5'd9, "div_5_0");
        run_op(INST_REMU, 32'd3, 32'd10, 5'd10, "remu_small");
        run_op(INST_DIV,  32'd7, 32'hFFFF_FFFE, 5'd12, "div_7_m2");

        // Flush at cycle 10 of an operation
        start_abort(INST_DIV, 32'd1000, 32'd3, 5'd13);
        repeat (10) @(negedge clk);
        check("flush_busy_before", 32'(busy_o), 32'h1);
        flush_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy_after", 32'(busy_o), 32'h0);
        repeat (40) @(negedge clk);
        run_op(INST_DIVU, 32'd9, 32'd3, 5'd14, "divu_after_flush");

        // Reset at cycle 15 of an operation
        start_abort(INST_DIV, 32'd1000, 32'd3, 5'd15);
        repeat (15) @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("midrst_result", result_o, 32'h0);
        check("midrst_ready", 32'(ready_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_waddr", 32'(reg_waddr_o), 32'h0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // start_i held through END: second request accepted the cycle after ready
        begin
            int  k;
            bit  seen;
            @(negedge clk);
            k = cyc;
            sb.push_back('{"hold_a", model_res(INST_DIV, 32'hFFFF_FFF9, 32'd2), 5'd16,
                           k + model_lat(INST_DIV, 32'hFFFF_FFF9, 32'd2)});
            start_i     = 1'b1;
            op_i        = INST_DIV;
            dividend_i  = 32'hFFFF_FFF9;
            divisor_i   = 32'd2;
            reg_waddr_i = 5'd16;
            seen = 1'b0;
            for (int w = 0; w < 60 && !seen; w++) begin
                @(negedge clk);
                if (ready_o) seen = 1'b1;
            end
            check("hold_a_done", 32'(seen), 32'd1);
            // Keep start_i high; swap in the second request during END.
            sb.push_back('{"hold_b", model_res(INST_REMU, 32'd100, 32'd7), 5'd17,
                           cyc + 1 + model_lat(INST_REMU, 32'd100, 32'd7)});
            op_i        = INST_REMU;
            dividend_i  = 32'd100;
            divisor_i   = 32'd7;
            reg_waddr_i = 5'd17;
            seen = 1'b0;
            for (int w = 0; w < 60 && !seen; w++) begin
                @(negedge clk);
                if (ready_o) seen = 1'b1;
            end
            start_i = 1'b0;
            check("hold_b_done", 32'(seen), 32'd1);
        end

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) :
                 (i % 3 == 1) ? ($urandom | 32'h8000_0000) : ($urandom >> 8);
            run_op(op, a, b, 5'($urandom_range(1, 31)), $sformatf("rnd%0d", i));
        end

        repeat (5) @(negedge clk);
        check("spurious_ready", 32'(spurious), 32'h0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
